// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl_if
// Brief    : Branch-unit / fetch handshake bundle for the PC redirect controller.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_redirect_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            Stall;
    logic            ExValid;
    logic            PCNextSrc;
    logic [XLEN-1:0] BranchTarget;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic            FetchValid;
    logic            Flush;
    logic            MisalignTrap;
    logic [XLEN-1:0] BadAddr;

    // Branch unit / EX side: supplies the decision, observes the fetch stream.
    modport master (
        output Stall,
        output ExValid,
        output PCNextSrc,
        output BranchTarget,
        input  PC,
        input  PCPlus4,
        input  FetchValid,
        input  Flush,
        input  MisalignTrap,
        input  BadAddr
    );

    // Fetch controller side.
    modport slave (
        input  Stall,
        input  ExValid,
        input  PCNextSrc,
        input  BranchTarget,
        output PC,
        output PCPlus4,
        output FetchValid,
        output Flush,
        output MisalignTrap,
        output BadAddr
    );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Brief    : Owns the PC, applies branch redirects, flushes the wrong path and
//            traps misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fetch_redirect_ctrl_if.slave bus
);

    localparam int unsigned         CNT_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    C_FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0]     C_PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_bad_addr;
    logic              r_flush;
    logic              r_trap;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_redirect;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_pc_plus4;

    assign w_redirect   = bus.ExValid & bus.PCNextSrc;
    assign w_misaligned = |bus.BranchTarget[1:0];
    assign w_pc_plus4   = r_pc + C_PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_bad_addr  <= '0;
            r_flush     <= 1'b0;
            r_trap      <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            // The trap flag is a single-cycle pulse unless re-armed below.
            r_trap <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        r_flush     <= 1'b1;
                        r_flush_cnt <= C_FLUSH_LOAD;
                        r_state     <= ST_FLUSH;
                        if (w_misaligned) begin
                            r_pc       <= TRAP_VECTOR;
                            r_bad_addr <= bus.BranchTarget;
                            r_trap     <= 1'b1;
                        end else begin
                            r_pc <= bus.BranchTarget;
                        end
                    end else if (!bus.Stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                ST_FLUSH: begin
                    // Redirect inputs are deliberately ignored while draining.
                    if (r_flush_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC           = r_pc;
    assign bus.PCPlus4      = w_pc_plus4;
    assign bus.FetchValid   = (r_state == ST_RUN) & ~bus.Stall;
    assign bus.Flush        = r_flush;
    assign bus.MisalignTrap = r_trap;
    assign bus.BadAddr      = r_bad_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Brief    : Cycle-table and hand-sequence checks of the fetch redirect controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int NROWS = 28;

    logic clk;
    logic rst_n;

    fetch_redirect_ctrl_if #(.XLEN(32)) bus ();

    fetch_redirect_ctrl #(
        .XLEN         (32),
        .RESET_PC     (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        stall;
        logic        exv;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        trap;
        logic [31:0] bad;
    } vec_t;

    vec_t tbl [NROWS];
    vec_t exp_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int idx, input logic st, input logic ev, input logic sr,
                                input logic [31:0] tg, input logic [31:0] pc, input logic fv,
                                input logic fl, input logic tr, input logic [31:0] bad);
        vec_t v;
        v.idx = idx; v.stall = st; v.exv = ev; v.src = sr; v.tgt = tg;
        v.pc = pc; v.fv = fv; v.fl = fl; v.trap = tr; v.bad = bad;
        return v;
    endfunction

    // Scoreboard side: each cycle's expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            logic [31:0] exp_p4;
            e = exp_q.pop_front();
            exp_p4 = e.pc + 32'd4;
            check($sformatf("row%0d PC", e.idx),           bus.PC,                   e.pc);
            check($sformatf("row%0d PCPlus4", e.idx),      bus.PCPlus4,              exp_p4);
            check($sformatf("row%0d FetchValid", e.idx),   {31'd0, bus.FetchValid},  {31'd0, e.fv});
            check($sformatf("row%0d Flush", e.idx),        {31'd0, bus.Flush},       {31'd0, e.fl});
            check($sformatf("row%0d MisalignTrap", e.idx), {31'd0, bus.MisalignTrap},{31'd0, e.trap});
            check($sformatf("row%0d BadAddr", e.idx),      bus.BadAddr,              e.bad);
        end
    end

    task automatic apply(input vec_t v);
        bus.Stall        = v.stall;
        bus.ExValid      = v.exv;
        bus.PCNextSrc    = v.src;
        bus.BranchTarget = v.tgt;
        exp_q.push_back(v);
    endtask

    task automatic drive_in(input logic st, input logic ev, input logic sr, input logic [31:0] tg);
        bus.Stall        = st;
        bus.ExValid      = ev;
        bus.PCNextSrc    = sr;
        bus.BranchTarget = tg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            idx st ev sr target        PC            fv fl tr BadAddr
        tbl[0]  = mk( 0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0, 0, 32'h0);    // BOOT
        tbl[1]  = mk( 1, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 32'h0);
        tbl[2]  = mk( 2, 0, 0, 0, 32'h0,        32'h0000_0004, 1, 0, 0, 32'h0);
        tbl[3]  = mk( 3, 0, 0, 0, 32'h0,        32'h0000_0008, 1, 0, 0, 32'h0);
        tbl[4]  = mk( 4, 0, 0, 0, 32'h0,        32'h0000_000C, 1, 0, 0, 32'h0);
        tbl[5]  = mk( 5, 1, 0, 0, 32'h0,        32'h0000_0010, 0, 0, 0, 32'h0);    // stall x3
        tbl[6]  = mk( 6, 1, 0, 0, 32'h0,        32'h0000_0010, 0, 0, 0, 32'h0);
        tbl[7]  = mk( 7, 1, 0, 0, 32'h0,        32'h0000_0010, 0, 0, 0, 32'h0);
        tbl[8]  = mk( 8, 0, 0, 0, 32'h0,        32'h0000_0010, 1, 0, 0, 32'h0);
        tbl[9]  = mk( 9, 0, 0, 0, 32'h0,        32'h0000_0014, 1, 0, 0, 32'h0);
        tbl[10] = mk(10, 0, 0, 0, 32'h0,        32'h0000_0018, 1, 0, 0, 32'h0);
        tbl[11] = mk(11, 0, 0, 0, 32'h0,        32'h0000_001C, 1, 0, 0, 32'h0);
        tbl[12] = mk(12, 0, 1, 1, 32'h200,      32'h0000_0020, 1, 0, 0, 32'h0);    // redirect
        tbl[13] = mk(13, 0, 0, 0, 32'h0,        32'h0000_0200, 0, 1, 0, 32'h0);
        tbl[14] = mk(14, 1, 1, 1, 32'h300,      32'h0000_0200, 0, 1, 0, 32'h0);    // ignored
        tbl[15] = mk(15, 0, 0, 0, 32'h0,        32'h0000_0200, 1, 0, 0, 32'h0);
        tbl[16] = mk(16, 1, 1, 1, 32'h202,      32'h0000_0204, 0, 0, 0, 32'h0);    // misaligned + stall
        tbl[17] = mk(17, 0, 0, 0, 32'h0,        32'h0000_0100, 0, 1, 1, 32'h202);
        tbl[18] = mk(18, 0, 0, 0, 32'h0,        32'h0000_0100, 0, 1, 0, 32'h202);
        tbl[19] = mk(19, 0, 0, 0, 32'h0,        32'h0000_0100, 1, 0, 0, 32'h202);
        tbl[20] = mk(20, 0, 1, 0, 32'h400,      32'h0000_0104, 1, 0, 0, 32'h202);  // not taken
        tbl[21] = mk(21, 0, 0, 1, 32'h500,      32'h0000_0108, 1, 0, 0, 32'h202);  // no ExValid
        tbl[22] = mk(22, 0, 1, 1, 32'hFFFF_FFFC,32'h0000_010C, 1, 0, 0, 32'h202);
        tbl[23] = mk(23, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 32'h202);
        tbl[24] = mk(24, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 32'h202);
        tbl[25] = mk(25, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 1, 0, 0, 32'h202);
        tbl[26] = mk(26, 0, 0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 32'h202);  // wrap
        tbl[27] = mk(27, 0, 0, 0, 32'h0,        32'h0000_0004, 1, 0, 0, 32'h202);

        rst_n = 1'b0;
        drive_in(0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset PC",           bus.PC,                    32'h0);
        check("reset FetchValid",   {31'd0, bus.FetchValid},   32'd0);
        check("reset Flush",        {31'd0, bus.Flush},        32'd0);
        check("reset MisalignTrap", {31'd0, bus.MisalignTrap}, 32'd0);
        check("reset BadAddr",      bus.BadAddr,               32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NROWS; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            apply(tbl[i]);
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);

        // Misaligned redirect, then asynchronous reset in the middle of the flush.
        @(posedge clk);
        #1 drive_in(0, 1, 1, 32'h0000_0003);
        @(posedge clk);
        #1 drive_in(0, 0, 0, 32'h0);
        #2;
        check("seq trap pulse",   {31'd0, bus.MisalignTrap}, 32'd1);
        check("seq trap PC",      bus.PC,                    32'h0000_0100);
        check("seq trap BadAddr", bus.BadAddr,               32'h0000_0003);
        check("seq trap Flush",   {31'd0, bus.Flush},        32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midflush rst Flush",      {31'd0, bus.Flush},        32'd0);
        check("midflush rst PC",         bus.PC,                    32'h0);
        check("midflush rst FetchValid", {31'd0, bus.FetchValid},   32'd0);
        check("midflush rst Trap",       {31'd0, bus.MisalignTrap}, 32'd0);
        check("midflush rst BadAddr",    bus.BadAddr,               32'h0);

        // Release again: one BOOT cycle, then sequential fetch resumes.
        @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        check("reboot FetchValid", {31'd0, bus.FetchValid}, 32'd0);
        check("reboot PC",         bus.PC,                  32'h0);
        @(posedge clk);
        #2;
        check("run FetchValid", {31'd0, bus.FetchValid}, 32'd1);
        check("run PC",         bus.PC,                  32'h0);
        @(posedge clk);
        #2;
        check("run PC+4", bus.PC, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
